trace_ram_arbiter: RTL and testbench
====================================

# trace_ram_arbiter

Arbitrates the single-port trace sample RAM between the VGA display reader and the acquisition writer in the oscilloscope datapath. It is clocked from the 40 MHz pixel clock and consumes the `vga_timing` counters and blanking flags (800x600 SVGA, 1056x628 total). During active video the display owns the RAM port with fixed latency. The writer is granted only in allowed blanking windows, and whole-frame freeze is supported for tear-free displays.

## Interface
Parameters:
- `ADDR_W`, 10: RAM address width; one sample per pixel column.
- `DATA_W`, 12: sample width.
- `H_ACTIVE`, 800: active pixels per line.

Ports:
- `clk`  in  1  pixel clock, 40 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `hcount`, `vcount`  in  11 each  pixel/line counters from `vga_timing`.
- `hblnk`, `vblnk`  in  1 each  blanking flags from `vga_timing`.
- `wr_mode`  in  1  0 = write in any blanking; 1 = write in vertical blanking only.
- `freeze`  in  1  freeze request; sampled at frame boundaries only.
- `wr_req`  in  1  writer request; held until acked.
- `wr_addr`  in  `ADDR_W`  writer address.
- `wr_data`  in  `DATA_W`  writer data.
- `wr_ack`  out  1  one-cycle grant; the write is issued in this cycle.
- `ram_en`, `ram_we`  out  1 each  RAM enable and write enable.
- `ram_addr`  out  `ADDR_W`  RAM address.
- `ram_wdata`  out  `DATA_W`  RAM write data.
- `ram_rdata`  in  `DATA_W`  RAM read data; 1-cycle read latency.
- `disp_rdata`  out  `DATA_W`  registered sample for the renderer.
- `disp_valid`  out  1  `disp_rdata` is valid.
- `frozen`  out  1  current frame is frozen.
- `frame_start`  out  1  one-cycle pulse on the `vblnk` falling edge.
- `frame_wr_cnt`  out  11  writes completed in the previous frame.

## Operation
Region FSM, state registered from `hblnk`/`vblnk`:
- `S_DISP`: `!hblnk && !vblnk`.
- `S_HBLK`: `hblnk && !vblnk`.
- `S_VBLK`: `vblnk`.

Display read:
- `disp_rd = !hblnk && !vblnk && hcount < H_ACTIVE`.
- When `disp_rd`: `ram_en=1`, `ram_we=0`, `ram_addr = hcount[ADDR_W-1:0]`.
- The display always wins; the writer is never granted when `disp_rd=1`.

Write grant, combinational: `wr_ack = wr_req && !disp_rd && !frozen && allow`.
- `allow = vblnk` when `wr_mode=1`.
- `allow = hblnk || vblnk` when `wr_mode=0`.
- On `wr_ack`: `ram_en=1`, `ram_we=1`, `ram_addr=wr_addr`, `ram_wdata=wr_data`.
- If neither a read nor a write is issued: `ram_en=0`, `ram_we=0`, and address/data are don't-care (driven 0).

Freeze:
- `frozen` updates only on the `vblnk` rising edge: `frozen <= freeze`.
- A `freeze` change mid-frame has no effect until the next `vblnk` rising edge.
- While `frozen=1`, display reads continue and no write is ever acked.

Write counter:
- An internal counter increments on each `wr_ack` and saturates at 2047.
- On the `vblnk` falling edge: `frame_wr_cnt <=` counter, and the counter resets to 0.
- A `wr_ack` in that same cycle is counted in the new frame (the counter loads 1).

Edge detection uses a registered copy `vblnk_q`. Both `vblnk` edges are detected relative to it.

## Timing
- Reset, synchronous: all registers clear.
  - `frozen=0`, `disp_valid=0`, `disp_rdata=0`, `frame_start=0`, `frame_wr_cnt=0`, `vblnk_q=0`, FSM = `S_VBLK`.
  - While `rst=1`, the combinational outputs `wr_ack`, `ram_en` and `ram_we` are forced to 0.
  - Reset mid-write: a write issued in the reset cycle is suppressed. The writer keeps `wr_req` high and is acked after reset per the normal rules.
- Display latency, fixed at 2 cycles: read issued at cycle N, `ram_rdata` valid at N+1, `disp_rdata`/`disp_valid` registered at N+2.
  - `disp_valid` is `disp_rd` delayed by 2 cycles.
  - The renderer compensates for this latency.
- Write: same-cycle grant. The writer may change `wr_addr`/`wr_data` or drop `wr_req` in the cycle after `wr_ack`.
- Writer throughput: one write per cycle for as long as the grant conditions hold.
- `frame_start` is asserted the cycle after `vblnk` falls, from `vblnk_q && !vblnk`.
- `wr_req` arriving in a cycle where `disp_rd` rises: no ack. It waits for the next allowed window.

## Test plan
- Display readback: preload addr 5 = 0xABC, run active video → `ram_addr=5` when `hcount=5`; `disp_rdata=0xABC` with `disp_valid=1` exactly 2 cycles later; no `ram_we` during active video.
- Mode 0 stall: `wr_req` raised at `hcount=100`, `vcount=10` → `wr_ack=0` until `hcount=800`; `wr_ack` at `hcount=800` with `ram_we=1` and `ram_addr=wr_addr`.
- Mode 1: `wr_req` raised at `hcount=900`, `vcount=10` → no ack in horizontal blanking; first ack at `vcount=600`, `hcount=0`.
- Freeze: `freeze=1` asserted at `vcount=300` → `frozen` rises at the next `vblnk` rise (`vcount=600`); zero acks for that whole frame; `freeze=0` → `frozen` clears at the following `vblnk` rise.
- Counter: 37 writes acked in one frame → `frame_wr_cnt=37` after `frame_start`; 3000 requests → `frame_wr_cnt=2047`.
- Reset: `rst` pulsed while `wr_ack=1` → `ram_we=0` in that cycle; all outputs at reset values; the request is acked in the next allowed window after reset.

Source files
------------

// File: rtl/trace_ram_arbiter.sv
// trace_ram_arbiter: shares the single-port trace sample RAM between the VGA
// display reader (fixed 2-cycle latency, always wins during active video) and
// the acquisition writer (granted only in blanking windows, blocked while a
// frame is frozen). Also reports per-frame write counts and frame boundaries.
module trace_ram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 12,
  parameter int H_ACTIVE = 800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  input  logic              hblnk,
  input  logic              vblnk,
  input  logic              wr_mode,
  input  logic              freeze,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_valid,
  output logic              frozen,
  output logic              frame_start,
  output logic [10:0]       frame_wr_cnt
);

  localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
  localparam logic [10:0] CNT_MAX_C  = 11'd2047;

  typedef enum logic [1:0] {
    S_DISP = 2'd0,
    S_HBLK = 2'd1,
    S_VBLK = 2'd2
  } region_t;

  region_t     state_r;
  logic        vblnk_q;
  logic        disp_rd_q_r;
  logic [10:0] wr_cnt_r;

  logic        disp_rd_s;
  logic        allow_s;
  logic        wr_ack_s;
  logic        vblnk_rise_s;
  logic        vblnk_fall_s;

  // vcount and the region state are observation-only; the arbitration is
  // decided directly from the blanking flags and hcount.
  logic        unused_sigs_s;
  assign unused_sigs_s = ^{vcount, state_r};

  // Request qualification: display reads, writer window, and vblnk edges.
  always_comb begin
    disp_rd_s    = 1'b0;
    allow_s      = 1'b0;
    wr_ack_s     = 1'b0;
    vblnk_rise_s = 1'b0;
    vblnk_fall_s = 1'b0;
    disp_rd_s    = !hblnk && !vblnk && (hcount < H_ACTIVE_C);
    if (wr_mode) begin
      allow_s = vblnk;
    end else begin
      allow_s = hblnk || vblnk;
    end
    wr_ack_s     = !rst && wr_req && !disp_rd_s && !frozen && allow_s;
    vblnk_rise_s = !vblnk_q && vblnk;
    vblnk_fall_s = vblnk_q && !vblnk;
  end

  // RAM port mux: display read has priority, then a granted write, else idle.
  always_comb begin
    wr_ack    = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    if (rst) begin
      wr_ack = 1'b0;
      ram_en = 1'b0;
      ram_we = 1'b0;
    end else if (disp_rd_s) begin
      ram_en   = 1'b1;
      ram_we   = 1'b0;
      ram_addr = hcount[ADDR_W-1:0];
    end else if (wr_ack_s) begin
      wr_ack    = 1'b1;
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
    end else begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  // Region FSM tracking which part of the raster is being scanned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_VBLK;
    end else begin
      case ({vblnk, hblnk})
        2'b00:   state_r <= S_DISP;
        2'b01:   state_r <= S_HBLK;
        2'b10:   state_r <= S_VBLK;
        2'b11:   state_r <= S_VBLK;
        default: state_r <= S_VBLK;
      endcase
    end
  end

  // Display pipeline: read issued at N, RAM data at N+1, registered at N+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_rd_q_r <= 1'b0;
      disp_valid  <= 1'b0;
      disp_rdata  <= {DATA_W{1'b0}};
    end else begin
      disp_rd_q_r <= disp_rd_s;
      disp_valid  <= disp_rd_q_r;
      if (disp_rd_q_r) begin
        disp_rdata <= ram_rdata;
      end else begin
        disp_rdata <= disp_rdata;
      end
    end
  end

  // Frame boundaries: vblnk history, frame_start pulse, freeze capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q     <= 1'b0;
      frame_start <= 1'b0;
      frozen      <= 1'b0;
    end else begin
      vblnk_q     <= vblnk;
      frame_start <= vblnk_fall_s;
      if (vblnk_rise_s) begin
        frozen <= freeze;
      end else begin
        frozen <= frozen;
      end
    end
  end

  // Per-frame write counter; a write in the boundary cycle opens the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_r     <= 11'd0;
      frame_wr_cnt <= 11'd0;
    end else if (vblnk_fall_s) begin
      frame_wr_cnt <= wr_cnt_r;
      wr_cnt_r     <= wr_ack_s ? 11'd1 : 11'd0;
    end else if (wr_ack_s && (wr_cnt_r != CNT_MAX_C)) begin
      wr_cnt_r <= wr_cnt_r + 11'd1;
    end else begin
      wr_cnt_r <= wr_cnt_r;
    end
  end

endmodule

// File: tb/tb_trace_ram_arbiter.sv
// Directed testbench for trace_ram_arbiter. Raster counters are driven
// directly (jumping between positions of interest) and a 1-cycle-latency
// RAM model sits on the RAM port.
module tb_trace_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblnk;
  logic        vblnk;
  logic        wr_mode;
  logic        freeze;
  logic        wr_req;
  logic [9:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic [11:0] disp_rdata;
  logic        disp_valid;
  logic        frozen;
  logic        frame_start;
  logic [10:0] frame_wr_cnt;

  // values applied at the start of the next cycle by step()
  logic p_rst;
  logic p_req;
  logic p_mode;
  logic p_freeze;

  int n_checks = 0;
  int n_fail   = 0;
  int acks;
  int wes;

  logic [11:0] mem [0:1023];

  trace_ram_arbiter #(.ADDR_W(10), .DATA_W(12), .H_ACTIVE(800)) dut (
    .clk          (clk),
    .rst          (rst),
    .hcount       (hcount),
    .vcount       (vcount),
    .hblnk        (hblnk),
    .vblnk        (vblnk),
    .wr_mode      (wr_mode),
    .freeze       (freeze),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .disp_rdata   (disp_rdata),
    .disp_valid   (disp_valid),
    .frozen       (frozen),
    .frame_start  (frame_start),
    .frame_wr_cnt (frame_wr_cnt)
  );

  always #5 clk = ~clk;

  // single-port RAM model, 1-cycle read latency; address 5 preloaded in reset
  always @(posedge clk) begin
    if (rst) begin
      mem[5] <= 12'hABC;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance one cycle: apply raster position and pending controls, let settle
  task automatic step(input int h, input int v);
    @(posedge clk);
    #1;
    hcount  = 11'(h);
    vcount  = 11'(v);
    hblnk   = (h >= 800);
    vblnk   = (v >= 600);
    rst     = p_rst;
    wr_req  = p_req;
    wr_mode = p_mode;
    freeze  = p_freeze;
    #1;
  endtask

  initial begin
    p_rst = 1'b1; p_req = 1'b1; p_mode = 1'b0; p_freeze = 1'b0;
    rst = 1'b1; wr_req = 1'b1; wr_mode = 1'b0; freeze = 1'b0;
    hcount = 11'd0; vcount = 11'd600; hblnk = 1'b0; vblnk = 1'b1;
    wr_addr = 10'h123; wr_data = 12'h5A5; ram_rdata = 12'h000;

    // reset during vblank with a pending request: port forced idle
    step(0, 600);
    step(0, 600);
    check_eq("rst_wr_ack", 32'(wr_ack), 32'd0);
    check_eq("rst_ram_en", 32'(ram_en), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_frozen", 32'(frozen), 32'd0);
    check_eq("rst_disp_valid", 32'(disp_valid), 32'd0);
    check_eq("rst_disp_rdata", 32'(disp_rdata), 32'd0);
    check_eq("rst_frame_start", 32'(frame_start), 32'd0);
    check_eq("rst_frame_wr_cnt", 32'(frame_wr_cnt), 32'd0);

    // display readback of preloaded address 5
    p_rst = 1'b0; p_req = 1'b0;
    for (int h = 0; h < 10; h++) begin
      step(h, 0);
      if (h == 1) check_eq("disp_valid_lat", 32'(disp_valid), 32'd0);
      if (h == 5) begin
        check_eq("rd_addr", 32'(ram_addr), 32'd5);
        check_eq("rd_en", 32'(ram_en), 32'd1);
        check_eq("rd_we", 32'(ram_we), 32'd0);
      end
      if (h == 7) begin
        check_eq("disp_rdata_5", 32'(disp_rdata), 32'hABC);
        check_eq("disp_valid_5", 32'(disp_valid), 32'd1);
      end
    end

    // mode 0: request during active video stalls until hblank
    p_req = 1'b1; acks = 0; wes = 0;
    for (int h = 100; h < 800; h++) begin
      step(h, 10);
      if (wr_ack) acks++;
      if (ram_we) wes++;
    end
    check_eq("m0_stall_acks", 32'(acks), 32'd0);
    check_eq("m0_active_we", 32'(wes), 32'd0);
    step(800, 10);
    check_eq("m0_ack", 32'(wr_ack), 32'd1);
    check_eq("m0_we", 32'(ram_we), 32'd1);
    check_eq("m0_addr", 32'(ram_addr), 32'h123);
    check_eq("m0_wdata", 32'(ram_wdata), 32'h5A5);
    p_req = 1'b0;
    step(801, 10);
    check_eq("m0_drop", 32'(wr_ack), 32'd0);

    // mode 1: no ack in hblank, first ack at vblank start
    p_mode = 1'b1; p_req = 1'b1; acks = 0;
    for (int h = 900; h < 1056; h++) begin
      step(h, 10);
      if (wr_ack) acks++;
    end
    step(1055, 599);
    if (wr_ack) acks++;
    check_eq("m1_hblank_acks", 32'(acks), 32'd0);
    step(0, 600);
    check_eq("m1_vblank_ack", 32'(wr_ack), 32'd1);
    p_req = 1'b0;
    step(1, 600);

    // frame boundary: two writes this frame, then readback of written word
    step(0, 0);
    step(1, 0);
    check_eq("fs_pulse", 32'(frame_start), 32'd1);
    check_eq("cnt_2", 32'(frame_wr_cnt), 32'd2);
    for (int h = 2; h < 294; h++) begin
      step(h, 0);
      if (h == 2) check_eq("fs_one_cycle", 32'(frame_start), 32'd0);
    end
    check_eq("rd_written", 32'(disp_rdata), 32'h5A5);

    // 37 writes in one frame
    p_mode = 1'b0; p_req = 1'b1;
    for (int h = 800; h < 837; h++) step(h, 0);
    p_req = 1'b0;
    step(837, 0);
    step(0, 600);
    step(0, 0);
    step(1, 0);
    check_eq("cnt_37", 32'(frame_wr_cnt), 32'd37);
    check_eq("cnt_37_fs", 32'(frame_start), 32'd1);

    // saturation, plus a write in the boundary cycle counted in the new frame
    p_mode = 1'b1; p_req = 1'b1;
    for (int i = 0; i < 3000; i++) step(0, 600);
    p_mode = 1'b0;
    step(800, 0);
    check_eq("edge_ack", 32'(wr_ack), 32'd1);
    p_req = 1'b0;
    step(801, 0);
    check_eq("cnt_sat", 32'(frame_wr_cnt), 32'd2047);
    step(0, 600);
    step(0, 0);
    step(1, 0);
    check_eq("cnt_edge_1", 32'(frame_wr_cnt), 32'd1);

    // freeze: mid-frame request has no effect until the next vblnk rise
    p_freeze = 1'b1;
    step(0, 300);
    check_eq("frz_mid", 32'(frozen), 32'd0);
    p_req = 1'b1;
    step(900, 599);
    check_eq("frz_pre_ack", 32'(wr_ack), 32'd1);
    p_req = 1'b0;
    step(0, 600);
    p_req = 1'b1; acks = 0;
    step(1, 600);
    check_eq("frz_set", 32'(frozen), 32'd1);
    for (int v = 601; v < 628; v++) begin
      step(0, v);
      if (wr_ack) acks++;
    end
    step(5, 1);
    check_eq("frz_disp_en", 32'(ram_en), 32'd1);
    p_freeze = 1'b0;
    for (int v = 0; v < 600; v += 20) begin
      for (int h = 800; h < 810; h++) begin
        step(h, v);
        if (wr_ack) acks++;
      end
    end
    check_eq("frz_acks", 32'(acks), 32'd0);
    check_eq("frz_hold", 32'(frozen), 32'd1);
    p_req = 1'b0;
    step(0, 600);
    p_req = 1'b1;
    step(1, 600);
    check_eq("frz_clear", 32'(frozen), 32'd0);
    check_eq("frz_clear_ack", 32'(wr_ack), 32'd1);

    // reset while a write is being acked
    p_rst = 1'b1;
    step(2, 600);
    check_eq("rstw_ack", 32'(wr_ack), 32'd0);
    check_eq("rstw_we", 32'(ram_we), 32'd0);
    check_eq("rstw_en", 32'(ram_en), 32'd0);
    p_rst = 1'b0;
    step(0, 10);
    check_eq("rstw_frozen", 32'(frozen), 32'd0);
    check_eq("rstw_cnt", 32'(frame_wr_cnt), 32'd0);
    check_eq("rstw_valid", 32'(disp_valid), 32'd0);
    check_eq("rstw_fs", 32'(frame_start), 32'd0);
    check_eq("rstw_disp_rise_ack", 32'(wr_ack), 32'd0);
    step(800, 10);
    check_eq("rstw_reack", 32'(wr_ack), 32'd1);
    check_eq("rstw_reack_we", 32'(ram_we), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
